// File: rtl/dnoc_pkg.sv
// Shared definitions for the NoC D-channel ingress demux: header layout, FSM encoding,
// latched DMA-write configuration record and a channel range helper.
package dnoc_pkg;

  localparam int KIND_B   = 12;
  localparam int RESP_B   = 13;
  localparam int SRC_LSB  = 14;
  localparam int BASE_LSB = 18;
  localparam int LEN_LSB  = 43;
  localparam int GAP_LSB  = 56;
  localparam int LOOP_LSB = 108;
  localparam int CH_LSB   = 160;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DMA  = 2'd1,
    CORE = 2'd2,
    DROP = 2'd3
  } d_state_e;

  typedef struct packed {
    logic [12:0]       base_addr;
    logic [12:0]       total_len;
    logic [3:0]        source_id;
    logic              resp_sel;
    logic [3:0][12:0]  loop_len;
    logic [3:0][12:0]  loop_gap;
  } d_hdr_cfg_t;

  function automatic logic chan_ok(input logic [3:0] ch, input int num_ch);
    return int'(ch) < num_ch;
  endfunction

endpackage

// File: rtl/dnoc_itf_in_d_demux_if.sv
// NoC ejection flit stream: the router drives flit/last/valid, the demux answers ready.
interface dnoc_itf_in_d_demux_if #(
  parameter int FLIT_W = 256
) ();
  logic [FLIT_W-1:0] out_flit;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_flit, output out_last, output out_valid, input out_ready);
  modport slave  (input out_flit, input out_last, input out_valid, output out_ready);
endinterface

// File: rtl/dnoc_skid_buf.sv
// Two-entry valid/ready register slice carrying {last, data}; in_ready is registered
// and stays high while fewer than two entries are held, so a streaming sink sees full rate.
module dnoc_skid_buf #(
  parameter int DATA_W = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DATA_W:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DATA_W:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);
  logic [1:0]      cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic [DATA_W:0] slot0_q, slot0_d;
  logic [DATA_W:0] slot1_q, slot1_d;
  logic            push, pop;

  always_comb begin
    push    = in_valid & in_ready_q;
    pop     = (cnt_q != 2'd0) & out_ready;
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = in_data;
        else               slot1_d = in_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = in_data;
        end else begin
          slot0_d = in_data;
        end
      end
      default: ;
    endcase
    in_ready_d = (cnt_d < 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  // payload registers carry no reset; occupancy alone qualifies them
  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = slot0_q;
endmodule

// File: rtl/dnoc_itf_in_d_demux.sv
// D-channel ingress demux: decodes each packet header, steers data flits to the DMA write
// engine or a core return port through skid buffers, and drops packets for absent channels.
module dnoc_itf_in_d_demux
  import dnoc_pkg::*;
#(
  parameter int FLIT_W      = 256,
  parameter int NUM_CORE_CH = 2,
  parameter int CH_W        = (NUM_CORE_CH > 1) ? $clog2(NUM_CORE_CH) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  dnoc_itf_in_d_demux_if.slave               noc,
  output logic [NUM_CORE_CH-1:0][FLIT_W-1:0] noc_in_core_rd_data,
  output logic [NUM_CORE_CH-1:0]             noc_in_core_rd_valid,
  output logic [NUM_CORE_CH-1:0]             noc_in_core_rd_last,
  input  logic [NUM_CORE_CH-1:0]             noc_in_core_rd_ready,
  output logic                               noc_cmd_dma_wr_req,
  input  logic                               noc_cmd_dma_wr_gnt,
  output logic [FLIT_W-1:0]                  noc_in_dma_wr_data,
  output logic                               noc_in_dma_wr_valid,
  output logic                               noc_in_dma_wr_last,
  input  logic                               noc_in_dma_wr_ready,
  output logic [12:0]                        n_cfg_d_w_ram_base_addr,
  output logic [12:0]                        n_cfg_d_w_ram_total_lenth,
  output logic [3:0]                         n_cfg_d_w_source_id,
  output logic                               n_cfg_d_w_resp_sel,
  output logic [3:0][12:0]                   n_cfg_d_w_loop_lenth,
  output logic [3:0][12:0]                   n_cfg_d_w_loop_gap,
  output logic                               err_bad_chan,
  output logic [15:0]                        drop_cnt
);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_DMA  = DMA;
  localparam logic [1:0] ST_CORE = CORE;
  localparam logic [1:0] ST_DROP = DROP;

  d_hdr_cfg_t            hdr_cfg, cfg_q, cfg_d, cfg_out;
  logic                  hdr_kind;
  logic [3:0]            hdr_ch;
  logic [1:0]            state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  err_q, err_d;
  logic [15:0]           drop_q, drop_d;
  logic                  out_rdy, dma_req, cfg_live, dma_empty;
  logic                  dma_in_valid, dma_in_ready;
  logic [NUM_CORE_CH-1:0] core_in_valid, core_in_ready;

  always_comb begin
    hdr_kind          = noc.out_flit[KIND_B];
    hdr_ch            = noc.out_flit[CH_LSB +: 4];
    hdr_cfg.resp_sel  = noc.out_flit[RESP_B];
    hdr_cfg.source_id = noc.out_flit[SRC_LSB +: 4];
    hdr_cfg.base_addr = noc.out_flit[BASE_LSB +: 13];
    hdr_cfg.total_len = noc.out_flit[LEN_LSB +: 13];
    for (int i = 0; i < 4; i++) begin
      hdr_cfg.loop_gap[i] = noc.out_flit[GAP_LSB + 13*i +: 13];
      hdr_cfg.loop_len[i] = noc.out_flit[LOOP_LSB + 13*i +: 13];
    end
  end

  assign dma_empty = ~noc_in_dma_wr_valid;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    cfg_d         = cfg_q;
    err_d         = 1'b0;
    drop_d        = drop_q;
    out_rdy       = 1'b0;
    dma_req       = 1'b0;
    dma_in_valid  = 1'b0;
    core_in_valid = '0;
    case (state_q)
      ST_IDLE: begin
        if (noc.out_valid) begin
          if (!hdr_kind) begin
            dma_req = dma_empty;
            out_rdy = noc_cmd_dma_wr_gnt & dma_empty;
          end else begin
            out_rdy = 1'b1;
          end
          if (out_rdy) begin
            if (!hdr_kind || hdr_cfg.resp_sel) begin
              cfg_d = hdr_cfg;
              if (!noc.out_last) state_d = ST_DMA;
            end else begin
              ch_d = hdr_ch[CH_W-1:0];
              if (chan_ok(hdr_ch, NUM_CORE_CH)) begin
                if (!noc.out_last) state_d = ST_CORE;
              end else begin
                err_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                if (!noc.out_last) state_d = ST_DROP;
              end
            end
          end
        end
      end
      ST_DMA: begin
        out_rdy      = dma_in_ready;
        dma_in_valid = noc.out_valid;
        if (noc.out_valid && out_rdy && noc.out_last) state_d = ST_IDLE;
      end
      ST_CORE: begin
        out_rdy             = core_in_ready[ch_q];
        core_in_valid[ch_q] = noc.out_valid;
        if (noc.out_valid && out_rdy && noc.out_last) state_d = ST_IDLE;
      end
      default: begin
        out_rdy = 1'b1;
        if (noc.out_valid && noc.out_last) state_d = ST_IDLE;
      end
    endcase
    if (rst) begin
      out_rdy       = 1'b0;
      dma_req       = 1'b0;
      dma_in_valid  = 1'b0;
      core_in_valid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cfg_q   <= '0;
      err_q   <= 1'b0;
      drop_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cfg_q   <= cfg_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // A header can only be presented live while it could be granted; otherwise the
  // previous packet's configuration stays visible to the DMA engine.
  assign cfg_live = (state_q == ST_IDLE) & noc.out_valid & dma_empty;
  assign cfg_out  = cfg_live ? hdr_cfg : cfg_q;

  assign n_cfg_d_w_ram_base_addr   = cfg_out.base_addr;
  assign n_cfg_d_w_ram_total_lenth = cfg_out.total_len;
  assign n_cfg_d_w_source_id       = cfg_out.source_id;
  assign n_cfg_d_w_resp_sel        = cfg_out.resp_sel;
  assign n_cfg_d_w_loop_lenth      = cfg_out.loop_len;
  assign n_cfg_d_w_loop_gap        = cfg_out.loop_gap;

  assign noc.out_ready          = out_rdy;
  assign noc_cmd_dma_wr_req     = dma_req;
  assign err_bad_chan           = err_q;
  assign drop_cnt               = drop_q;

  dnoc_skid_buf #(.DATA_W(FLIT_W)) u_dma_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({noc.out_last, noc.out_flit}),
    .in_valid  (dma_in_valid),
    .in_ready  (dma_in_ready),
    .out_data  ({noc_in_dma_wr_last, noc_in_dma_wr_data}),
    .out_valid (noc_in_dma_wr_valid),
    .out_ready (noc_in_dma_wr_ready)
  );

  for (genvar g = 0; g < NUM_CORE_CH; g++) begin : g_core
    dnoc_skid_buf #(.DATA_W(FLIT_W)) u_core_skid (
      .clk       (clk),
      .rst       (rst),
      .in_data   ({noc.out_last, noc.out_flit}),
      .in_valid  (core_in_valid[g]),
      .in_ready  (core_in_ready[g]),
      .out_data  ({noc_in_core_rd_last[g], noc_in_core_rd_data[g]}),
      .out_valid (noc_in_core_rd_valid[g]),
      .out_ready (noc_in_core_rd_ready[g])
    );
  end
endmodule
